// File: rtl/result_matrix_buffer.sv
// result_matrix_buffer
//
// Collects an n x n matrix of 32-bit elements streamed in row-major order over a
// valid/ready interface, then hands the complete matrix to a downstream writer.
// The writer reads elements combinationally by (i, j) index and releases the
// buffer with done, after which the buffer refills from (0, 0).
//
// State table:
//   state | meaning
//   FILL  | accepting elements (in_ready = 1); the last position moves to FULL
//   FULL  | one cycle; start pulse to the writer; no input accepted
//   DRAIN | writer reads the matrix; waits for done, then back to FILL
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        upstream element valid
//   in_data[31:0]   upstream element value
//   in_last         upstream's own marker for the final element (checked only)
//   in_ready        element accepted this cycle (decoded from the state register)
//   start           one-cycle pulse, matrix complete
//   i, j            writer row / column index
//   value[31:0]     mem[i][j], combinational; 0 for out-of-range indices
//   done            writer finished with the matrix (honoured only in DRAIN)
//   busy            high from the first accepted element until done is taken
//   last_err        sticky: in_last disagreed with the position counters

module result_matrix_buffer #(
    parameter int n  = 8,
    parameter int IW = $clog2(n)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          start,
    input  logic [IW-1:0] i,
    input  logic [IW-1:0] j,
    output logic [31:0]   value,
    input  logic          done,
    output logic          busy,
    output logic          last_err
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(n - 1);
    localparam logic [IW:0]   N_EXT    = (IW + 1)'(n);

    state_t        state, state_nx;
    logic [IW-1:0] row, col;
    logic          xfer;
    logic          at_end;
    logic [31:0]   mem [n][n];

    assign in_ready = (state == FILL);
    assign start    = (state == FULL);
    assign xfer     = in_valid && in_ready;
    assign at_end   = (row == LAST_IDX) && (col == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            FILL:    if (xfer && at_end) state_nx = FULL;
            FULL:    state_nx = DRAIN;
            DRAIN:   if (done) state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    // Position counters are authoritative; in_last only feeds the error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (xfer) begin
            if (col == LAST_IDX) begin
                col <= '0;
                row <= (row == LAST_IDX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            last_err <= 1'b0;
        end else begin
            if (state == DRAIN && done) begin
                busy <= 1'b0;
            end else if (xfer) begin
                busy <= 1'b1;
            end
            if (xfer && (in_last != at_end)) begin
                last_err <= 1'b1;
            end
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[row][col] <= in_data;
        end
    end

    // Indices can exceed n-1 only when n is not a power of two.
    always_comb begin
        value = '0;
        if (({1'b0, i} < N_EXT) && ({1'b0, j} < N_EXT)) begin
            value = mem[i][j];
        end
    end

endmodule

// File: tb/tb_result_matrix_buffer.sv
module tb_result_matrix_buffer;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        done = 1'b0;
    logic [2:0]  i = '0;
    logic [2:0]  j = '0;
    logic        in_ready, start, busy, last_err;
    logic [31:0] value;

    result_matrix_buffer #(.n(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .start    (start),
        .i        (i),
        .j        (j),
        .value    (value),
        .done     (done),
        .busy     (busy),
        .last_err (last_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] exp_mem [64];
    int          start_q [$];

    typedef struct {
        int          ri;
        int          rj;
        logic [31:0] ev;
    } rd_t;
    rd_t  rd_q [$];
    logic rd_pend = 1'b0;
    rd_t  r_cur;
    int   e_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: start pulses and read responses are checked against queued expectations.
    always @(negedge clk) begin
        if (start === 1'b1) begin
            n_chk++;
            if (start_q.size() == 0) begin
                n_fail++;
                $display("FAIL start_unexpected: start=1 at cycle %0d, expected no start", cyc);
            end else begin
                e_cyc = start_q.pop_front();
                if (e_cyc != cyc) begin
                    n_fail++;
                    $display("FAIL start_cycle: start at cycle %0d expected cycle %0d", cyc, e_cyc);
                end
            end
        end
        if (rd_pend) begin
            n_chk++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL read_underflow: read with no expectation, value %0d", value);
            end else begin
                r_cur = rd_q.pop_front();
                if (value !== r_cur.ev) begin
                    n_fail++;
                    $display("FAIL read(%0d,%0d): got %0d expected %0d", r_cur.ri, r_cur.rj, value, r_cur.ev);
                end
            end
        end
    end

    task automatic send_elem(input logic [31:0] d, input bit lst, input bit gap, input int idx, input bit fin);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = lst;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout: in_ready %0b expected 1 within 50 cycles", in_ready);
        end
        @(posedge clk); #1;
        exp_mem[idx] = d;
        if (fin) start_q.push_back(cyc);
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_matrix(input logic [31:0] base, input bit gap, input bit hold);
        for (int k = 0; k < 64; k++) begin
            send_elem(base + 32'(k), k == 63, gap, k, k == 63);
        end
        in_last = 1'b0;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic read_chk(input int ii, input int jj);
        i = 3'(ii);
        j = 3'(jj);
        rd_q.push_back('{ii, jj, exp_mem[ii * 8 + jj]});
        rd_pend = 1'b1;
        @(negedge clk); #1;
        rd_pend = 1'b0;
    endtask

    task automatic do_done(input int hold);
        @(posedge clk); #1;
        done = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_done", 32'(in_ready), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        for (int h = 1; h < hold; h++) begin
            @(posedge clk); #1;
            chk("ready_done_held", 32'(in_ready), 32'd1);
        end
        done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last_err", 32'(last_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Row-major fill, in_valid held high
        chk("busy_idle", 32'(busy), 32'd0);
        send_matrix(32'd0, 1'b0, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        chk("t1_last_err", 32'(last_err), 32'd0);
        read_chk(3, 5);
        read_chk(7, 7);
        read_chk(0, 0);
        chk("r35_hand", value, 32'd0);
        i = 3'd3; j = 3'd5; #1;
        chk("r35_direct", value, 32'd29);
        do_done(3);

        // Gapped input
        send_matrix(32'd100, 1'b1, 1'b0);
        read_chk(0, 0);
        read_chk(7, 7);
        read_chk(4, 1);
        do_done(1);

        // Backpressure: in_valid stays high through FULL and DRAIN
        send_matrix(32'd200, 1'b0, 1'b1);
        in_data = 32'd9999;
        for (int k = 0; k <= 10; k++) begin
            if (k == 10) done = 1'b1;
            read_chk(0, 0);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        done = 1'b0;
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
        chk("bp_busy_clear", 32'(busy), 32'd0);
        send_matrix(32'd5000, 1'b0, 1'b0);
        read_chk(0, 0);
        read_chk(7, 7);
        do_done(1);

        // Back-to-back matrices
        send_matrix(32'd0, 1'b0, 1'b0);
        do_done(1);
        send_matrix(32'd1000, 1'b0, 1'b0);
        read_chk(2, 2);
        i = 3'd2; j = 3'd2; #1;
        chk("b2b_r22_direct", value, 32'd1018);
        do_done(1);

        // in_last on element 10, missing on element 63
        for (int k = 0; k < 64; k++) begin
            send_elem(32'd3000 + 32'(k), k == 10, 1'b0, k, k == 63);
            if (k == 9)  chk("last_err_before", 32'(last_err), 32'd0);
            if (k == 10) chk("last_err_set", 32'(last_err), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("last_err_sticky", 32'(last_err), 32'd1);
        read_chk(7, 7);
        do_done(1);

        // Reset mid-fill
        for (int k = 0; k < 20; k++) begin
            send_elem(32'd4000 + 32'(k), 1'b0, 1'b0, k, 1'b0);
        end
        in_valid = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_start", 32'(start), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_last_err", 32'(last_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_matrix(32'd6000, 1'b0, 1'b0);
        read_chk(0, 0);
        read_chk(2, 4);
        read_chk(7, 7);
        do_done(1);

        repeat (3) @(posedge clk);
        #1;
        chk("start_q_drained", 32'(start_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/result_matrix_buffer.md
# result_matrix_buffer

Collects the n×n result matrix produced by the multiplier core and hands it to the file writer stage. It accepts one 32-bit element per valid/ready transfer in row-major order and stores it in an internal n×n array. Once the matrix is complete it pulses `start` to the writer, serves `value` for the writer's (i, j) indices, and refills after the writer reports `done`.

## Interface
- `n`, 8: matrix dimension. Legal range n ≥ 2.
- `IW`, `$clog2(n)`: index width (derived; do not override).
- `clk` input 1: single clock; everything is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream element valid.
- `in_data` input 32: upstream element value.
- `in_last` input 1: upstream marks the element it considers the final (n−1, n−1) element.
- `in_ready` output 1: buffer accepts the element this cycle.
- `start` output 1: one-cycle pulse to the writer; the matrix is complete.
- `i` input IW: writer row index.
- `j` input IW: writer column index.
- `value` output 32: `mem[i][j]`, combinational read.
- `done` input 1: the writer has finished the matrix.
- `busy` output 1: high from the first accepted element until `done` is taken.
- `last_err` output 1: sticky flag for an `in_last` mismatch. Cleared only by reset.

## Operation
- A transfer occurs when `in_valid && in_ready`. On a transfer, `in_data` is written to `mem[row][col]`. Then `col` increments; when `col == n−1` it wraps to 0 and `row` increments.
- States:
  - FILL: `in_ready = 1`. A transfer at `row == col == n−1` goes to FULL, and the counters wrap to (0, 0).
  - FULL: lasts one cycle. `start = 1`, `in_ready = 0`. Then goes to DRAIN.
  - DRAIN: `in_ready = 0`. Waits for `done == 1`, then goes to FILL.
- `value` is valid in every state. It is stable in FULL and DRAIN because no writes occur there. In FILL it reflects partially written or stale data; the writer does not sample it in FILL.
- `busy`:
  - Set on the first transfer of a matrix.
  - Cleared on the cycle DRAIN exits.
- `last_err`: set when a transfer has `in_last` differing from `(row == n−1 && col == n−1)`. The mismatch does not alter counting; the position counters are authoritative.
- `done` is ignored in FILL and in FULL.
- `i` and `j` values ≥ n (possible when n is not a power of 2) return 0 on `value`.
- Array contents are not reset. Only state, counters and flags are reset.

## Timing
- Reset values:
  - State FILL, row = col = 0.
  - `in_ready = 1`.
  - `start = 0`, `busy = 0`, `last_err = 0`.
  - `value` is don't-care until written.
- Reset assertion mid-operation, in any state: immediately returns to the reset values. Any partially collected matrix is abandoned; the next transfer writes (0, 0).
- `in_ready` is a registered state decode. It does not depend combinationally on `in_valid`.
- Final transfer at cycle T:
  - `start` is high in cycle T+1 only.
  - `in_ready` is low from T+1.
- `done` sampled high in DRAIN at cycle D:
  - `in_ready` is high from D+1.
  - `busy` is low from D+1.
  - `done` held high for several cycles causes no second exit.
- `done` high in the same cycle as `start`: ignored. The writer must raise `done` no earlier than the cycle after `start`.
- Latency:
  - Write to readable: 1 cycle (the write commits at the clock edge).
  - Read: 0 cycles (combinational).
- Minimum matrix period: n² transfer cycles + 1 (FULL) + 1 (DRAIN with immediate `done`).

## Test plan
- Row-major fill (n = 8):
  - Stimulus: stream 0..63 with `in_valid` held high and `in_last` on the 64th element.
  - Response: `start` pulses exactly once, the cycle after the 64th transfer. Reading (i, j) gives 8i + j, e.g. (3, 5) → 29 and (7, 7) → 63. `last_err` stays 0.
- Gapped input:
  - Stimulus: toggle `in_valid` 1/0 and send 64 values 100..163.
  - Response: `start` fires after the 64th accepted value only. (0, 0) → 100, (7, 7) → 163.
- Backpressure:
  - Stimulus: hold `in_valid` high through FULL and DRAIN. Assert `done` 10 cycles after `start`.
  - Response: `in_ready` stays 0 for 11 cycles. No writes occur; (0, 0) is unchanged. Refill resumes at (0, 0) on the cycle after `done`.
- Back-to-back matrices:
  - Stimulus: send matrix A = 0..63, then `done`, then matrix B = 1000..1063.
  - Response: two `start` pulses. During the second DRAIN, (2, 2) → 1018.
- `in_last` errors:
  - Stimulus: `in_last` on element 10, and separately no `in_last` on element 63.
  - Response: `last_err` = 1 from the cycle after element 10. `start` still fires after element 63.
- Reset mid-fill:
  - Stimulus: assert `rst_n = 0` after 20 transfers, release, then send 64 values.
  - Response: outputs return to reset values immediately. `start` fires only after 64 new transfers, with no early `start`.
